// File: rtl/disp_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed display: prescaled digit select,
// double-buffered nibbles, blanking guard, digit masking and leading-zero suppression.
module disp_scan_ctrl #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned BLANK = 1,
    parameter int unsigned CW    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] d,
    input  logic        en,
    input  logic [3:0]  digit_mask,
    input  logic        lz_blank,
    output logic [1:0]  sel,
    output logic [3:0]  i3,
    output logic [3:0]  i2,
    output logic [3:0]  i1,
    output logic [3:0]  i0,
    output logic [3:0]  an,
    output logic        frame
);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(BLANK);

    logic [CW-1:0] cnt;
    logic [15:0]   pending;
    logic          pend_v;
    logic [15:0]   disp;
    logic          slot_end;
    logic          boundary;
    logic [3:0]    nz;
    logic [3:0]    visible;

    assign slot_end = en && (cnt == CNT_LAST);
    assign boundary = slot_end && (sel == 2'd3);

    // Prescaler, digit select, double buffer and frame pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt     <= '0;
            sel     <= 2'd0;
            pending <= 16'h0000;
            pend_v  <= 1'b0;
            disp    <= 16'h0000;
            frame   <= 1'b0;
        end else begin
            frame <= boundary;
            if (en) begin
                if (slot_end) begin
                    cnt <= '0;
                    sel <= sel + 2'd1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            // Swap takes the pre-edge pending value; a same-cycle load refills it.
            if (boundary && pend_v) begin
                disp   <= pending;
                pend_v <= 1'b0;
            end
            if (load) begin
                pending <= d;
                pend_v  <= 1'b1;
            end
        end
    end

    assign i3 = disp[15:12];
    assign i2 = disp[11:8];
    assign i1 = disp[7:4];
    assign i0 = disp[3:0];

    // A digit survives leading-zero suppression if it or any higher digit is nonzero.
    assign nz = {|disp[15:12], |disp[11:8], |disp[7:4], |disp[3:0]};

    always_comb begin
        visible = 4'b1111;
        if (lz_blank) begin
            visible[3] = nz[3];
            visible[2] = nz[3] | nz[2];
            visible[1] = nz[3] | nz[2] | nz[1];
            visible[0] = 1'b1;
        end
    end

    always_comb begin
        an = 4'b1111;
        if (en && (cnt >= CNT_GUARD) && digit_mask[sel] && visible[sel]) begin
            an[sel] = 1'b0;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed self-checking bench for disp_scan_ctrl with DIV=4, BLANK=1.
module tb_disp_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load;
    logic [15:0] d;
    logic        en;
    logic [3:0]  digit_mask;
    logic        lz_blank;
    logic [1:0]  sel;
    logic [3:0]  i3, i2, i1, i0;
    logic [3:0]  an;
    logic        frame;

    int n_checks = 0;
    int n_fail   = 0;

    disp_scan_ctrl #(.DIV(4), .BLANK(1), .CW(16)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .d(d), .en(en),
        .digit_mask(digit_mask), .lz_blank(lz_blank), .sel(sel),
        .i3(i3), .i2(i2), .i1(i1), .i0(i0), .an(an), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected anode pattern for slot s at prescaler phase c given which digits should light.
    function automatic logic [3:0] want_an(input int s, input int c, input logic [3:0] lit);
        logic [3:0] r;
        r = 4'b1111;
        if (c != 0 && lit[s]) r[s] = 1'b0;
        return r;
    endfunction

    function automatic logic [15:0] shown();
        return {i3, i2, i1, i0};
    endfunction

    initial begin
        reset_n = 1'b0; load = 1'b1; d = 16'hFFFF;
        en = 1'b1; digit_mask = 4'b1111; lz_blank = 1'b0;

        // Reset held 3 cycles with load asserted; load must be ignored.
        tick(3);
        reset_n = 1'b1; load = 1'b0; d = 16'h0000;
        #1;
        check("rst_sel", 16'(sel), 16'h0);
        check("rst_disp", shown(), 16'h0000);
        check("rst_an", 16'(an), 16'hF);
        check("rst_frame", 16'(frame), 16'h0);

        tick(16);
        check("first_frame", 16'(frame), 16'h1);
        check("first_frame_disp", shown(), 16'h0000);

        // Scan timing with 1234.
        load = 1'b1; d = 16'h1234;
        tick(1);
        load = 1'b0;
        tick(14);
        check("pre_swap_disp", shown(), 16'h0000);
        tick(1);
        check("swap_disp", shown(), 16'h1234);
        for (int j = 0; j < 16; j++) begin
            check("scan_sel", 16'(sel), 16'(j / 4));
            check("scan_an", 16'(an), 16'(want_an(j / 4, j % 4, 4'b1111)));
            check("scan_frame", 16'(frame), (j == 0) ? 16'h1 : 16'h0);
            tick(1);
        end
        check("frame_period", 16'(frame), 16'h1);
        check("frame_period_sel", 16'(sel), 16'h0);

        // Anti-tearing: load during slot 1.
        tick(4);
        check("tear_sel", 16'(sel), 16'h1);
        load = 1'b1; d = 16'hABCD;
        tick(1);
        load = 1'b0;
        for (int j = 0; j < 11; j++) begin
            check("tear_hold", shown(), 16'h1234);
            tick(1);
        end
        check("tear_frame", 16'(frame), 16'h1);
        check("tear_swap", shown(), 16'hABCD);

        // Load mid-frame, then again on the boundary cycle.
        tick(6);
        load = 1'b1; d = 16'h1111;
        tick(1);
        load = 1'b0;
        tick(8);
        check("bnd_sel", 16'(sel), 16'h3);
        load = 1'b1; d = 16'h2222;
        tick(1);
        load = 1'b0;
        check("bnd_frame", 16'(frame), 16'h1);
        check("bnd_first", shown(), 16'h1111);
        for (int j = 0; j < 15; j++) begin
            tick(1);
            check("bnd_hold", shown(), 16'h1111);
        end
        tick(1);
        check("bnd_frame2", 16'(frame), 16'h1);
        check("bnd_second", shown(), 16'h2222);

        // Leading-zero suppression: 0040 lights digits 1 and 0 only.
        lz_blank = 1'b1; load = 1'b1; d = 16'h0040;
        tick(1);
        load = 1'b0;
        tick(15);
        check("lz_disp", shown(), 16'h0040);
        for (int j = 0; j < 16; j++) begin
            check("lz40_an", 16'(an), 16'(want_an(j / 4, j % 4, 4'b0011)));
            tick(1);
        end
        load = 1'b1; d = 16'h0000;
        tick(1);
        load = 1'b0;
        tick(15);
        check("lz0_disp", shown(), 16'h0000);
        for (int j = 0; j < 16; j++) begin
            check("lz0_an", 16'(an), 16'(want_an(j / 4, j % 4, 4'b0001)));
            tick(1);
        end

        // Freeze with en=0 at sel=2, cnt=1.
        lz_blank = 1'b0;
        tick(9);
        check("frz_sel_pre", 16'(sel), 16'h2);
        check("frz_an_pre", 16'(an), 16'hB);
        en = 1'b0;
        #1;
        check("frz_an_dark", 16'(an), 16'hF);
        for (int j = 0; j < 5; j++) begin
            tick(1);
            check("frz_sel", 16'(sel), 16'h2);
            check("frz_an", 16'(an), 16'hF);
            check("frz_frame", 16'(frame), 16'h0);
        end
        en = 1'b1;
        #1;
        check("resume_an", 16'(an), 16'hB);
        tick(2);
        check("resume_sel_hold", 16'(sel), 16'h2);
        tick(1);
        check("resume_sel_next", 16'(sel), 16'h3);
        check("resume_an_guard", 16'(an), 16'hF);

        // Digit mask 0101 from the start of slot 3.
        digit_mask = 4'b0101;
        for (int j = 0; j < 16; j++) begin
            check("mask_sel", 16'(sel), 16'((3 + j / 4) % 4));
            check("mask_an", 16'(an), 16'(want_an((3 + j / 4) % 4, j % 4, 4'b0101)));
            tick(1);
        end

        // Reset mid-frame discards pending data.
        digit_mask = 4'b1111;
        load = 1'b1; d = 16'h5678;
        tick(1);
        load = 1'b0;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("midrst_sel", 16'(sel), 16'h0);
        tick(16);
        check("midrst_frame", 16'(frame), 16'h1);
        check("midrst_disp", shown(), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
